// File: rtl/uart_bus_pkg.sv
// Shared types and constants for the host-side UART register bus sequencer.
package uart_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } bus_state_e;

    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [7:0] TIMEOUT_READ_VALUE = 8'hFF;

endpackage

// File: rtl/bus_access_controller.sv
// Sequences one host req/ack transaction onto the UART register bus:
// decoder setup, single strobe, wait states, ack-or-timeout, host handshake.
module bus_access_controller
    import uart_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  hostReq,
    input  logic                  hostWrite,
    input  logic [ADDR_WIDTH-1:0] hostAddress,
    input  logic [DATA_WIDTH-1:0] hostWriteData,
    output logic                  hostAck,
    output logic                  hostError,
    output logic [DATA_WIDTH-1:0] hostReadData,
    output logic [ADDR_WIDTH-1:0] addressOut,
    output logic                  decodeEnable,
    output logic                  writeStrobe,
    output logic                  readStrobe,
    output logic [DATA_WIDTH-1:0] busWriteData,
    input  logic [DATA_WIDTH-1:0] busReadData,
    input  logic                  busAck
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("WAIT_STATES must be in 0..15");
    end

    bus_state_e            state_q, state_d;
    logic [3:0]            waitCount_q, waitCount_d;
    logic [7:0]            timeoutCount_q, timeoutCount_d;
    logic [7:0]            timeoutNext;
    logic                  isWrite_q, isWrite_d;
    logic [ADDR_WIDTH-1:0] addressOut_q, addressOut_d;
    logic [DATA_WIDTH-1:0] busWriteData_q, busWriteData_d;
    logic [DATA_WIDTH-1:0] hostReadData_q, hostReadData_d;
    logic                  hostError_q, hostError_d;
    logic                  hostAck_q, hostAck_d;
    logic                  decodeEnable_q, decodeEnable_d;
    logic                  writeStrobe_q, writeStrobe_d;
    logic                  readStrobe_q, readStrobe_d;

    assign timeoutNext = timeoutCount_q + 8'd1;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            waitCount_q    <= '0;
            timeoutCount_q <= '0;
            isWrite_q      <= 1'b0;
            addressOut_q   <= '0;
            busWriteData_q <= '0;
            hostReadData_q <= '0;
            hostError_q    <= 1'b0;
            hostAck_q      <= 1'b0;
            decodeEnable_q <= 1'b0;
            writeStrobe_q  <= 1'b0;
            readStrobe_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            waitCount_q    <= waitCount_d;
            timeoutCount_q <= timeoutCount_d;
            isWrite_q      <= isWrite_d;
            addressOut_q   <= addressOut_d;
            busWriteData_q <= busWriteData_d;
            hostReadData_q <= hostReadData_d;
            hostError_q    <= hostError_d;
            hostAck_q      <= hostAck_d;
            decodeEnable_q <= decodeEnable_d;
            writeStrobe_q  <= writeStrobe_d;
            readStrobe_q   <= readStrobe_d;
        end
    end

    // Outputs are decoded from the next state so each registered output
    // lines up with the state it belongs to.
    always_comb begin
        state_d        = state_q;
        waitCount_d    = waitCount_q;
        timeoutCount_d = timeoutCount_q;
        isWrite_d      = isWrite_q;
        addressOut_d   = addressOut_q;
        busWriteData_d = busWriteData_q;
        hostReadData_d = hostReadData_q;
        hostError_d    = hostError_q;
        hostAck_d      = 1'b0;
        decodeEnable_d = 1'b0;
        writeStrobe_d  = 1'b0;
        readStrobe_d   = 1'b0;

        case (state_q)
            IDLE: begin
                hostError_d = 1'b0;
                if (hostReq) begin
                    isWrite_d      = hostWrite;
                    addressOut_d   = hostAddress;
                    busWriteData_d = hostWriteData;
                    decodeEnable_d = 1'b1;
                    state_d        = SETUP;
                end
            end
            SETUP: begin
                decodeEnable_d = 1'b1;
                writeStrobe_d  = isWrite_q;
                readStrobe_d   = !isWrite_q;
                state_d        = ACCESS;
            end
            ACCESS: begin
                decodeEnable_d = 1'b1;
                waitCount_d    = 4'(WAIT_STATES);
                timeoutCount_d = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                decodeEnable_d = 1'b1;
                if (waitCount_q != 4'd0) begin
                    waitCount_d = waitCount_q - 4'd1;
                end else if (busAck) begin
                    if (!isWrite_q) hostReadData_d = busReadData;
                    decodeEnable_d = 1'b0;
                    state_d        = DONE;
                end else begin
                    timeoutCount_d = timeoutNext;
                    if (timeoutNext == 8'(TIMEOUT_CYCLES)) begin
                        hostError_d = 1'b1;
                        if (!isWrite_q) hostReadData_d = DATA_WIDTH'(TIMEOUT_READ_VALUE);
                        decodeEnable_d = 1'b0;
                        state_d        = DONE;
                    end
                end
            end
            DONE: begin
                // Ack is raised for at least one cycle even if the host already
                // dropped its request, so an aborted transaction still completes.
                hostAck_d = 1'b1;
                if (hostAck_q && !hostReq) begin
                    hostAck_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hostAck      = hostAck_q;
    assign hostError    = hostError_q;
    assign hostReadData = hostReadData_q;
    assign addressOut   = addressOut_q;
    assign decodeEnable = decodeEnable_q;
    assign writeStrobe  = writeStrobe_q;
    assign readStrobe   = readStrobe_q;
    assign busWriteData = busWriteData_q;

endmodule

// File: tb/tb_bus_access_controller.sv
// Directed bench for bus_access_controller: vector table plus reset/abort sequences.
module tb_bus_access_controller;

    logic       clock = 1'b0;
    logic       resetN;
    logic       hostReq;
    logic       hostWrite;
    logic [2:0] hostAddress;
    logic [7:0] hostWriteData;
    logic       hostAck;
    logic       hostError;
    logic [7:0] hostReadData;
    logic [2:0] addressOut;
    logic       decodeEnable;
    logic       writeStrobe;
    logic       readStrobe;
    logic [7:0] busWriteData;
    logic [7:0] busReadData;
    logic       busAck;

    int tests  = 0;
    int failed = 0;

    bus_access_controller dut (
        .clock         (clock),
        .resetN        (resetN),
        .hostReq       (hostReq),
        .hostWrite     (hostWrite),
        .hostAddress   (hostAddress),
        .hostWriteData (hostWriteData),
        .hostAck       (hostAck),
        .hostError     (hostError),
        .hostReadData  (hostReadData),
        .addressOut    (addressOut),
        .decodeEnable  (decodeEnable),
        .writeStrobe   (writeStrobe),
        .readStrobe    (readStrobe),
        .busWriteData  (busWriteData),
        .busReadData   (busReadData),
        .busAck        (busAck)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         ackAfter;   // -1: busAck tied high; else edges after strobe
        int         expAck;     // edge (capture = 1) at which hostAck is seen high
        logic       expErr;
        logic [7:0] expRdata;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   strobeEdge = 0;
        int   wcnt = 0;
        int   rcnt = 0;
        int   ackEdge = -1;
        int   latchBad = 0;
        int   setupOk = 0;
        int   deAtAck = 1;
        hostReq       = 1'b1;
        hostWrite     = v.wr;
        hostAddress   = v.addr;
        hostWriteData = v.wdata;
        busReadData   = v.rdata;
        busAck        = (v.ackAfter < 0);
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 1) setupOk = int'(decodeEnable && !writeStrobe && !readStrobe);
            if (writeStrobe) begin wcnt++; strobeEdge = n; end
            if (readStrobe)  begin rcnt++; strobeEdge = n; end
            if (decodeEnable && (addressOut !== v.addr || busWriteData !== v.wdata)) latchBad++;
            hostWrite     = 1'($urandom_range(0, 1));
            hostAddress   = 3'($urandom);
            hostWriteData = 8'($urandom);
            if (v.ackAfter >= 0 && strobeEdge > 0 && n >= strobeEdge + v.ackAfter) busAck = 1'b1;
            if (hostAck) begin
                ackEdge = n;
                deAtAck = int'(decodeEnable);
                break;
            end
        end
        check($sformatf("v%0d ack_edge", idx), ackEdge, v.expAck);
        check($sformatf("v%0d hostError", idx), int'(hostError), int'(v.expErr));
        check($sformatf("v%0d hostReadData", idx), int'(hostReadData), int'(v.expRdata));
        check($sformatf("v%0d write_strobes", idx), wcnt, int'(v.wr));
        check($sformatf("v%0d read_strobes", idx), rcnt, int'(!v.wr));
        check($sformatf("v%0d strobe_edge", idx), strobeEdge, 2);
        check($sformatf("v%0d setup_visible", idx), setupOk, 1);
        check($sformatf("v%0d latched_inputs_bad", idx), latchBad, 0);
        check($sformatf("v%0d decode_in_done", idx), deAtAck, 0);
        step();
        step();
        check($sformatf("v%0d ack_held", idx), int'(hostAck), 1);
        hostReq = 1'b0;
        step();
        check($sformatf("v%0d ack_release", idx), int'(hostAck), 0);
        busAck = 1'b0;
    endtask

    initial begin
        int ackSeen;
        int pulses;
        int strobes;
        logic [7:0] abortData;

        vecs[0] = '{1'b1, 3'd5, 8'hA5, 8'h00,  -1,  6, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 3'd2, 8'h11, 8'h3C,   6, 10, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 3'd7, 8'h22, 8'h44, 100, 20, 1'b1, 8'hFF};
        vecs[3] = '{1'b1, 3'd3, 8'h5A, 8'h66,   0,  6, 1'b0, 8'hFF};
        vecs[4] = '{1'b0, 3'd0, 8'h33, 8'h81,  16, 20, 1'b0, 8'h81};
        vecs[5] = '{1'b0, 3'd4, 8'h77, 8'h00,  17, 20, 1'b1, 8'hFF};
        vecs[6] = '{1'b0, 3'd1, 8'h88, 8'hC3,   2,  6, 1'b0, 8'hC3};
        vecs[7] = '{1'b0, 3'd6, 8'h99, 8'h7E,   3,  7, 1'b0, 8'h7E};

        // Reset held with a pending request: everything stays at zero.
        resetN        = 1'b0;
        hostReq       = 1'b1;
        hostWrite     = 1'b1;
        hostAddress   = 3'd4;
        hostWriteData = 8'h99;
        busReadData   = 8'h00;
        busAck        = 1'b1;
        step();
        step();
        check("reset hostAck", int'(hostAck), 0);
        check("reset hostError", int'(hostError), 0);
        check("reset hostReadData", int'(hostReadData), 0);
        check("reset addressOut", int'(addressOut), 0);
        check("reset busWriteData", int'(busWriteData), 0);
        check("reset decodeEnable", int'(decodeEnable), 0);
        check("reset strobes", int'({writeStrobe, readStrobe}), 0);
        resetN = 1'b1;
        step();
        check("release decodeEnable", int'(decodeEnable), 1);
        check("release strobes", int'({writeStrobe, readStrobe}), 0);
        check("release addressOut", int'(addressOut), 4);
        check("release busWriteData", int'(busWriteData), 8'h99);
        ackSeen = 0;
        for (int n = 0; n < 20 && !ackSeen; n++) begin
            step();
            if (hostAck) ackSeen = 1;
        end
        check("release txn ack", ackSeen, 1);
        hostReq = 1'b0;
        busAck  = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Request dropped during WAIT: ack must still pulse exactly once.
        hostReq       = 1'b1;
        hostWrite     = 1'b0;
        hostAddress   = 3'd2;
        busReadData   = 8'h5B;
        busAck        = 1'b1;
        for (int n = 1; n <= 4; n++) step();
        hostReq = 1'b0;
        pulses    = 0;
        abortData = 8'h00;
        for (int n = 0; n < 12; n++) begin
            step();
            if (hostAck) begin
                pulses++;
                abortData = hostReadData;
            end
        end
        check("abort ack_pulses", pulses, 1);
        check("abort hostReadData", int'(abortData), 8'h5B);
        check("abort idle_decode", int'(decodeEnable), 0);
        busAck = 1'b0;

        // Reset asserted while the strobe is on the bus.
        hostReq       = 1'b1;
        hostWrite     = 1'b1;
        hostAddress   = 3'd6;
        hostWriteData = 8'hE7;
        step();
        step();
        check("access writeStrobe", int'(writeStrobe), 1);
        #2 resetN = 1'b0;
        #1;
        check("async strobes", int'({writeStrobe, readStrobe}), 0);
        check("async decodeEnable", int'(decodeEnable), 0);
        check("async addressOut", int'(addressOut), 0);
        hostReq = 1'b0;
        step();
        resetN = 1'b1;
        strobes = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (writeStrobe || readStrobe || hostAck || decodeEnable) strobes++;
        end
        check("post_reset activity", strobes, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
